// File: rtl/reg_check_monitor_pkg.sv
// reg_check_monitor_pkg: FSM state encoding and default sizing shared by the checker files
package reg_check_monitor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_CHECKS = 8;
  localparam int DEF_CYC_W = 32;
endpackage

// File: rtl/reg_check_monitor_if.sv
// reg_check_monitor_if: snooped register-file write port plus check-table configuration handshake
// master drives wr_en/wr_addr/wr_data and cfg_valid/cfg_idx/cfg_reg/cfg_exp/cfg_en; slave returns cfg_ready
interface reg_check_monitor_if
  import reg_check_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int IW = $clog2(NUM_CHECKS);
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic cfg_valid;
  logic cfg_ready;
  logic [IW-1:0] cfg_idx;
  logic [AW-1:0] cfg_reg;
  logic [DATA_W-1:0] cfg_exp;
  logic cfg_en;
  modport master (
    output wr_en, wr_addr, wr_data, cfg_valid, cfg_idx, cfg_reg, cfg_exp, cfg_en,
    input  cfg_ready
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, cfg_valid, cfg_idx, cfg_reg, cfg_exp, cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/reg_check_table.sv
// reg_check_table: check-table storage (enable, register index, expected value) with one write port and one indexed read
// we_i/w_*_i write entry w_idx_i; r_idx_i selects the entry presented on r_reg_o/r_exp_o/r_en_o
module reg_check_table
  import reg_check_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  localparam int AW = $clog2(NUM_REGS),
  localparam int IW = $clog2(NUM_CHECKS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we_i,
  input  logic [IW-1:0] w_idx_i,
  input  logic [AW-1:0] w_reg_i,
  input  logic [DATA_W-1:0] w_exp_i,
  input  logic w_en_i,
  input  logic [IW-1:0] r_idx_i,
  output logic [AW-1:0] r_reg_o,
  output logic [DATA_W-1:0] r_exp_o,
  output logic r_en_o
);
  logic [NUM_CHECKS-1:0] en_q;
  logic [AW-1:0] reg_q [NUM_CHECKS];
  logic [DATA_W-1:0] exp_q [NUM_CHECKS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        reg_q[i] <= '0;
        exp_q[i] <= '0;
      end
    end else if (we_i) begin
      en_q[w_idx_i] <= w_en_i;
      reg_q[w_idx_i] <= w_reg_i;
      exp_q[w_idx_i] <= w_exp_i;
    end
  end
  assign r_reg_o = reg_q[r_idx_i];
  assign r_exp_o = exp_q[r_idx_i];
  assign r_en_o = en_q[r_idx_i];
endmodule

// File: rtl/reg_check_monitor.sv
// reg_check_monitor: mirrors register-file writes into a shadow file and, at a target run cycle, checks it against a programmable table
// bus: snooped writes + cfg handshake; start/target_cycle launch a run; busy/done/pass/fail_count/first_fail_idx/cycle_cnt report it
module reg_check_monitor
  import reg_check_monitor_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_CHECKS = DEF_NUM_CHECKS,
  parameter int CYC_W = DEF_CYC_W,
  localparam int AW = $clog2(NUM_REGS),
  localparam int IW = $clog2(NUM_CHECKS)
) (
  input  logic clk,
  input  logic rst_n,
  reg_check_monitor_if.slave bus,
  input  logic start,
  input  logic [CYC_W-1:0] target_cycle,
  output logic busy,
  output logic done,
  output logic pass,
  output logic [IW:0] fail_count,
  output logic [IW-1:0] first_fail_idx,
  output logic [CYC_W-1:0] cycle_cnt
);
  localparam logic [IW-1:0] LAST = IW'(NUM_CHECKS - 1);
  state_t state_q, state_d;
  logic [CYC_W-1:0] cnt_q, cnt_d, tgt_q, tgt_d;
  logic [IW-1:0] idx_q, idx_d, first_q, first_d;
  logic [IW:0] fails_q, fails_d;
  logic pass_q, pass_d;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [AW-1:0] t_reg;
  logic [DATA_W-1:0] t_exp;
  logic t_en, hit;
  assign bus.cfg_ready = state_q == IDLE;
  reg_check_table #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_CHECKS(NUM_CHECKS)) u_table (
    .clk(clk),
    .rst_n(rst_n),
    .we_i(bus.cfg_valid && bus.cfg_ready),
    .w_idx_i(bus.cfg_idx),
    .w_reg_i(bus.cfg_reg),
    .w_exp_i(bus.cfg_exp),
    .w_en_i(bus.cfg_en),
    .r_idx_i(idx_q),
    .r_reg_o(t_reg),
    .r_exp_o(t_exp),
    .r_en_o(t_en)
  );
  // registered shadow value: a write landing in an entry's own compare cycle is seen only by later entries
  assign hit = t_en && shadow_q[t_reg] != t_exp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else if (bus.wr_en) begin
      shadow_q[bus.wr_addr] <= bus.wr_data;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tgt_q <= '0;
      idx_q <= '0;
      first_q <= '0;
      fails_q <= '0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
      idx_q <= idx_d;
      first_q <= first_d;
      fails_q <= fails_d;
      pass_q <= pass_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    tgt_d = tgt_q;
    idx_d = idx_q;
    first_d = first_q;
    fails_d = fails_q;
    pass_d = pass_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        cnt_d = CYC_W'(1);
        tgt_d = target_cycle;
        idx_d = '0;
        first_d = '0;
        fails_d = '0;
        pass_d = 1'b0;
      end
      RUN: begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + CYC_W'(1);
        // cnt starts at 1, so targets 0 and 1 both leave on the first run cycle
        state_d = cnt_q >= tgt_q ? CHECK : RUN;
      end
      CHECK: begin
        fails_d = hit ? fails_q + (IW+1)'(1) : fails_q;
        first_d = hit && fails_q == '0 ? idx_q : first_q;
        idx_d = idx_q == LAST ? idx_q : idx_q + IW'(1);
        state_d = idx_q == LAST ? DONE : CHECK;
        pass_d = idx_q == LAST ? fails_d == '0 : pass_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q == RUN || state_q == CHECK;
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign fail_count = fails_q;
  assign first_fail_idx = first_q;
  assign cycle_cnt = cnt_q;
endmodule

// File: tb/tb_reg_check_monitor.sv
// tb_reg_check_monitor: scoreboard bench; expected run results come from a table/shadow model evaluated per entry compare cycle
module tb_reg_check_monitor;
  localparam int DW = 32, NR = 32, NC = 8, CW = 6, AW = 5, IW = 3;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {bit pass; int fails; int first; int cnt;} exp_t;
  logic clk = 0, rst_n = 1, start = 0;
  logic [CW-1:0] target_cycle = '0;
  logic busy, done, pass;
  logic [IW:0] fail_count;
  logic [IW-1:0] first_fail_idx;
  logic [CW-1:0] cycle_cnt;
  int checks = 0, passed = 0;
  exp_t sb[$];
  logic [DW-1:0] mshadow [NR];
  bit t_en [NC];
  int t_reg [NC];
  logic [DW-1:0] t_exp [NC];
  int wc[$], wa[$];
  logic [DW-1:0] wd[$];
  bit idle;

  reg_check_monitor_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_CHECKS(NC)) bus ();

  reg_check_monitor #(.DATA_W(DW), .NUM_REGS(NR), .NUM_CHECKS(NC), .CYC_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .target_cycle(target_cycle),
    .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; start = 0; bus.wr_en = 0; bus.cfg_valid = 0;
    for (int i = 0; i < NR; i++) mshadow[i] = '0;
    for (int i = 0; i < NC; i++) begin t_en[i] = 0; t_reg[i] = 0; t_exp[i] = '0; end
    wc.delete(); wa.delete(); wd.delete();
    idle = 1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_count", fail_count, 0);
    chk("rst_first_fail_idx", first_fail_idx, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cfg_write(input int idx, input int r, input logic [DW-1:0] e, input bit en);
    @(negedge clk);
    chk("cfg_ready", bus.cfg_ready, idle);
    bus.cfg_valid = 1; bus.cfg_idx = IW'(idx); bus.cfg_reg = AW'(r); bus.cfg_exp = e; bus.cfg_en = en;
    if (idle) begin t_en[idx] = en; t_reg[idx] = r; t_exp[idx] = e; end
    @(negedge clk);
    bus.cfg_valid = 0;
  endtask

  task automatic snoop(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = d;
    mshadow[a] = d;
    @(negedge clk);
    bus.wr_en = 0;
  endtask

  task automatic load_basic();
    cfg_write(0, 0, 16, 1);
    cfg_write(1, 1, 17, 1);
    cfg_write(2, 2, 0, 1);
    cfg_write(3, 3, 17, 1);
  endtask

  task automatic wsched(input int c, input int a, input logic [DW-1:0] d);
    wc.push_back(c); wa.push_back(a); wd.push_back(d);
  endtask

  task automatic gen_writes(input int tgt);
    int t = tgt <= 1 ? 1 : tgt;
    for (int c = 1; c <= t + NC; c++)
      if ($urandom_range(1) == 1) wsched(c, int'($urandom_range(3)), DW'($urandom_range(3)));
  endtask

  // entry i compares in run cycle T+1+i and so sees every write issued in cycles up to T+i
  task automatic push_expect(input int tgt);
    int t = tgt <= 1 ? 1 : tgt;
    int f = 0, first = 0;
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      logic [DW-1:0] v;
      if (!t_en[i]) continue;
      v = mshadow[t_reg[i]];
      foreach (wc[k]) if (wc[k] <= t + i && wa[k] == t_reg[i]) v = wd[k];
      if (v != t_exp[i]) begin
        if (f == 0) first = i;
        f++;
      end
    end
    e.pass = f == 0; e.fails = f; e.first = first; e.cnt = t + 1 > CMAX ? CMAX : t + 1;
    sb.push_back(e);
  endtask

  task automatic run(input int tgt, input int abort_at, input bit noise);
    int t = tgt <= 1 ? 1 : tgt;
    int k = 0;
    if (abort_at == 0) push_expect(tgt);
    @(negedge clk);
    start = 1; target_cycle = CW'(tgt); idle = 0;
    @(negedge clk);
    start = 0;
    for (int c = 1; c <= t + NC; c++) begin
      if (c == abort_at) begin
        do_reset();
        return;
      end
      if (c == 1) begin
        chk("first_cycle_cnt", cycle_cnt, 1);
        chk("run_busy", busy, 1);
        chk("run_cfg_ready", bus.cfg_ready, 0);
      end
      if (c == t + NC) chk("done_early", done, 0);
      bus.wr_en = 0;
      if (k < wc.size() && wc[k] == c) begin
        bus.wr_en = 1; bus.wr_addr = AW'(wa[k]); bus.wr_data = wd[k];
        k++;
      end
      bus.cfg_valid = noise && $urandom_range(1) == 1;
      bus.cfg_idx = IW'($urandom); bus.cfg_reg = AW'($urandom); bus.cfg_exp = DW'($urandom);
      bus.cfg_en = 1'($urandom);
      @(negedge clk);
    end
    bus.wr_en = 0; bus.cfg_valid = 0;
    chk("done_at_end", done, 1);
    chk("busy_at_end", busy, 0);
    foreach (wc[i]) mshadow[wa[i]] = wd[i];
    wc.delete(); wa.delete(); wd.delete();
  endtask

  initial begin
    bit prev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !prev) begin
        chk("sb_has_entry", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("pass", pass, e.pass);
          chk("fail_count", fail_count, e.fails);
          chk("first_fail_idx", first_fail_idx, e.first);
          chk("done_cycle_cnt", cycle_cnt, e.cnt);
        end
      end
      prev = done === 1'b1;
    end
  end

  initial begin
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.cfg_valid = 0; bus.cfg_idx = '0; bus.cfg_reg = '0; bus.cfg_exp = '0; bus.cfg_en = 0;
    do_reset();
    load_basic();
    wsched(2, 0, 16); wsched(4, 1, 17); wsched(6, 3, 17);
    run(8, 0, 0);
    do_reset();
    load_basic();
    wsched(2, 0, 16); wsched(4, 1, 5); wsched(6, 3, 18);
    run(8, 0, 1);
    do_reset();
    cfg_write(0, 0, 16, 1);
    wsched(8, 0, 16);
    run(8, 0, 0);
    do_reset();
    cfg_write(0, 0, 16, 1);
    wsched(9, 0, 16);
    run(8, 0, 0);
    do_reset();
    run(0, 0, 1);
    run(1, 0, 0);
    cfg_write(0, 2, 7, 1);
    gen_writes(5);
    run(5, 0, 1);
    do_reset();
    load_basic();
    gen_writes(8);
    run(8, 4, 0);
    gen_writes(6);
    run(6, 0, 0);
    do_reset();
    cfg_write(0, 1, 3, 1);
    gen_writes(CMAX);
    run(CMAX, 0, 0);
    repeat (12) begin
      int tgt;
      do_reset();
      for (int i = 0; i < NC; i++)
        cfg_write(i, int'($urandom_range(3)), DW'($urandom_range(3)), 1'($urandom_range(1)));
      repeat (2) snoop(int'($urandom_range(3)), DW'($urandom_range(3)));
      tgt = int'($urandom_range(12));
      gen_writes(tgt);
      run(tgt, 0, 1);
      gen_writes(3);
      run(3, 0, 0);
    end
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
